// File: rtl/ex_muldiv_unit_pkg.sv
// Shared pipeline definitions for the EX-stage multiply/divide unit:
// op encodings, the func-field-to-op map and FSM state encodings.
package ex_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  // Decoder helper: R-type func field to muldiv op.
  function automatic md_op_e func_to_op(input logic [5:0] func);
    md_op_e op_v;
    case (func)
      FUNC_MULT:  op_v = MD_MULT;
      FUNC_MULTU: op_v = MD_MULTU;
      FUNC_DIV:   op_v = MD_DIV;
      FUNC_DIVU:  op_v = MD_DIVU;
      default:    op_v = MD_MULT;
    endcase
    return op_v;
  endfunction

endpackage

// File: rtl/ex_muldiv_datapath.sv
// Iterative mul/div datapath: operand capture, one shift-add or restoring
// divide step per cycle, and combinational sign fix-up of the final result.
module muldiv_datapath
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  md_op_e                op_s;
  logic                  is_div_s;
  logic                  a_neg_s;
  logic                  b_neg_s;
  logic [XLEN-1:0]       a_mag_s;
  logic [XLEN-1:0]       b_mag_s;

  logic                  is_div_r;
  logic                  neg_res_r;
  logic                  neg_rem_r;
  logic                  div0_r;
  logic [XLEN-1:0]       opnd_r;
  logic [2*XLEN-1:0]     acc_r;

  logic [XLEN:0]         mul_sum_s;
  logic [XLEN:0]         div_shl_s;
  logic [XLEN:0]         div_diff_s;
  logic [2*XLEN-1:0]     acc_next_s;
  logic [2*XLEN-1:0]     prod_s;
  logic [XLEN-1:0]       quo_s;
  logic [XLEN-1:0]       rem_s;

  assign op_s     = md_op_e'(op);
  assign is_div_s = (op_s == MD_DIV) || (op_s == MD_DIVU);

  // Operand magnitudes; only signed ops look at the sign bit, so -2^31 maps to 2^31.
  always_comb begin
    a_neg_s = 1'b0;
    b_neg_s = 1'b0;
    if ((op_s == MD_MULT) || (op_s == MD_DIV)) begin
      a_neg_s = a[XLEN-1];
      b_neg_s = b[XLEN-1];
    end else begin
      a_neg_s = 1'b0;
      b_neg_s = 1'b0;
    end
    a_mag_s = a_neg_s ? (~a + XLEN'(1'b1)) : a;
    b_mag_s = b_neg_s ? (~b + XLEN'(1'b1)) : b;
  end

  // One iteration: MUL adds the multiplicand on a set LSB then shifts right;
  // DIV shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                 (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    div_shl_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    div_diff_s = div_shl_s - {1'b0, opnd_r};
    if (!is_div_r) begin
      acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end else if (!div_diff_s[XLEN]) begin
      acc_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    end else begin
      acc_next_s = {div_shl_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    end
  end

  // Operand/flag capture at launch and accumulator update while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
      opnd_r    <= {XLEN{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
    end else if (load) begin
      is_div_r  <= is_div_s;
      neg_res_r <= a_neg_s ^ b_neg_s;
      neg_rem_r <= a_neg_s;
      div0_r    <= is_div_s && (b == {XLEN{1'b0}});
      opnd_r    <= is_div_s ? b_mag_s : a_mag_s;
      acc_r     <= {{XLEN{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
    end else if (step) begin
      acc_r     <= acc_next_s;
    end else begin
      acc_r     <= acc_r;
    end
  end

  // Sign fix-up. A zero divisor leaves the remainder equal to A and forces the quotient to all ones.
  always_comb begin
    prod_s = neg_res_r ? (~acc_r + (2*XLEN)'(1'b1)) : acc_r;
    quo_s  = neg_res_r ? (~acc_r[XLEN-1:0] + XLEN'(1'b1)) : acc_r[XLEN-1:0];
    rem_s  = neg_rem_r ? (~acc_r[2*XLEN-1:XLEN] + XLEN'(1'b1)) : acc_r[2*XLEN-1:XLEN];
    if (is_div_r) begin
      res_hi = rem_s;
      res_lo = div0_r ? {XLEN{1'b1}} : quo_s;
    end else begin
      res_hi = prod_s[2*XLEN-1:XLEN];
      res_lo = prod_s[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit: sequencing FSM, iteration counter,
// architectural HI/LO registers and the MFHI/MFLO stall request.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  input  logic            mf_req,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  md_state_e        state_r;
  md_state_e        state_next_s;
  logic [CNT_W-1:0] counter_r;
  logic [XLEN-1:0]  hi_r;
  logic [XLEN-1:0]  lo_r;
  logic             busy_r;
  logic             done_r;

  logic             load_s;
  logic             step_s;
  logic             fix_s;
  logic             idle_s;
  logic [XLEN-1:0]  res_hi_s;
  logic [XLEN-1:0]  res_lo_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: start is only honoured from IDLE, so a start while busy is dropped.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (counter_r == CNT_W'(1'b1)) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FIX:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM control outputs.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    fix_s  = 1'b0;
    idle_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        idle_s = 1'b1;
        load_s = start;
      end
      ST_RUN:  step_s = 1'b1;
      ST_FIX:  fix_s  = 1'b1;
      default: idle_s = 1'b1;
    endcase
  end

  // Iteration counter: loaded with XLEN at launch, one decrement per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_r <= {CNT_W{1'b0}};
    end else if (load_s) begin
      counter_r <= CNT_W'(XLEN);
    end else if (step_s) begin
      counter_r <= counter_r - CNT_W'(1'b1);
    end else begin
      counter_r <= counter_r;
    end
  end

  // HI/LO: result at FIX, MTHI/MTLO only while idle (including the launch edge).
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= {XLEN{1'b0}};
      lo_r <= {XLEN{1'b0}};
    end else if (fix_s) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else begin
      if (idle_s && hi_we) begin
        hi_r <= wdata;
      end else begin
        hi_r <= hi_r;
      end
      if (idle_s && lo_we) begin
        lo_r <= wdata;
      end else begin
        lo_r <= lo_r;
      end
    end
  end

  // Status flags: busy spans RUN and FIX, done pulses for the cycle after FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= fix_s;
      if (load_s) begin
        busy_r <= 1'b1;
      end else if (fix_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load_s),
    .step   (step_s),
    .op     (op),
    .a      (rs_val),
    .b      (rt_val),
    .res_hi (res_hi_s),
    .res_lo (res_lo_s)
  );

  assign hi    = hi_r;
  assign lo    = lo_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign stall = mf_req & (busy_r | start);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: table of directed mul/div vectors
// plus hand-written sequences for stall, reset abort and MTHI/MTLO timing.
module tb_ex_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            mf_req;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;
  logic            stall;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  vec_t vecs[13];

  ex_muldiv_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .mf_req (mf_req),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge of the first busy cycle
  // with the operand buses scrambled to prove they were captured.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; op = ~o; rs_val = ~a; rt_val = ~b;
  endtask

  // Walk cycles (starting at cycle 1 after launch) until done, bounded.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int bc;
    int bad;

    vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[1]  = '{2'd0, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m7x3"};
    vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
    vecs[3]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
    vecs[4]  = '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, "divu_by0"};
    vecs[5]  = '{2'd1, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, "multu_6x7"};
    vecs[6]  = '{2'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_neg_by0"};
    vecs[7]  = '{2'd3, 32'hFFFFFFFF, 32'h00000007, 32'h00000003, 32'h24924924, "divu_max_d7"};
    vecs[8]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minsq"};
    vecs[9]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2"};
    vecs[10] = '{2'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, "mult_maxxm1"};
    vecs[11] = '{2'd1, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, "multu_2p31x2"};
    vecs[12] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, "divu_2p31"};

    reset = 1'b1; start = 1'b0; op = 2'd0; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; mf_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(cyc, bc);
      check({vecs[i].name, "_done_cycle"}, cyc, 34);
      check({vecs[i].name, "_busy_cycles"}, bc, 33);
      check({vecs[i].name, "_busy_in_done"}, {31'b0, busy}, 32'h0);
      check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, {31'b0, done}, 32'h0);
    end

    // Stall held through an op, with a stray start mid-flight.
    @(negedge clk);
    start = 1'b1; op = 2'd1; rs_val = 32'd6; rt_val = 32'd7; mf_req = 1'b1;
    #1 check("stall_at_start", {31'b0, stall}, 32'h1);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; bad = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (stall !== 1'b1) bad++;
      start = (cyc == 10);
      op = 2'd3; rs_val = 32'd100; rt_val = 32'd0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("stall_while_busy", bad, 0);
    check("stall_done_cycle", cyc, 34);
    check("stall_in_done", {31'b0, stall}, 32'h0);
    check("stray_start_hi", hi, 32'h0);
    check("stray_start_lo", lo, 32'h2A);
    mf_req = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_start_idle", {31'b0, busy}, 32'h0);

    // Reset at cycle 10 of a DIVU aborts with cleared HI/LO and no done.
    launch(2'd3, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1 || busy === 1'b1) bad++;
      @(negedge clk);
    end
    check("abort_no_done", bad, 0);
    launch(2'd1, 32'd6, 32'd7);
    wait_done(cyc, bc);
    check("after_abort_hi", hi, 32'h0);
    check("after_abort_lo", lo, 32'd42);

    // MTHI/MTLO while idle, MTLO ignored while busy.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'h1234);
    lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_idle", lo, 32'h5678);
    check("mtlo_keeps_hi", hi, 32'h1234);
    launch(2'd1, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    lo_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_busy_ignored", lo, 32'h5678);
    wait_done(cyc, bc);
    check("mtlo_busy_final_lo", lo, 32'h0F);
    check("mtlo_busy_final_hi", hi, 32'h0);

    // MTHI on the same edge as an accepted start: applies, then overwritten.
    @(negedge clk);
    start = 1'b1; op = 2'd1; rs_val = 32'd2; rt_val = 32'd3;
    hi_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("mthi_with_start", hi, 32'hABCD);
    check("mthi_with_start_busy", {31'b0, busy}, 32'h1);
    wait_done(cyc, bc);
    check("mthi_overwritten_hi", hi, 32'h0);
    check("mthi_overwritten_lo", lo, 32'h6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage.
- Consumes the decoded operands and func from the ID/EX pipeline register outputs and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Owns the architectural HI/LO registers.
- Drives a stall request to the hazard logic, which freezes IF/ID and bubbles ID/EX while MFHI/MFLO wait on an in-flight operation.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  launch op this cycle (EX holds MULT/MULTU/DIV/DIVU)
op  in  2  0=MULT 1=MULTU 2=DIV 3=DIVU
rs_val  in  XLEN  operand A (dividend / multiplicand), forwarded value
rt_val  in  XLEN  operand B (divisor / multiplier), forwarded value
hi_we  in  1  MTHI write
lo_we  in  1  MTLO write
wdata  in  XLEN  MTHI/MTLO data
mf_req  in  1  ID holds MFHI/MFLO/MTHI/MTLO
hi  out  XLEN  HI register
lo  out  XLEN  LO register
busy  out  1  operation in flight
done  out  1  one-cycle pulse, HI/LO just updated
stall  out  1  to hazard unit

Behaviour:
- Reset is synchronous, active-high, clock clk. Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-operation aborts the op. HI/LO are cleared and no done pulse is produced.
- FSM states: IDLE, RUN, FIX.
- IDLE -> RUN on an edge with start=1:
  - Latch op and the magnitudes of the operands. Magnitudes are taken only for signed ops; the unsigned magnitude of -2^31 is 2^31.
  - Latch result-sign flags.
  - Set counter=XLEN. Set busy=1 from the next cycle.
- RUN: one iteration per cycle, counter decrements, RUN -> FIX when counter reaches 1 at the edge.
  - MUL: shift-add on a 2*XLEN accumulator, one multiplier bit per cycle.
  - DIV: restoring division, one quotient bit per cycle.
- FIX: one cycle of sign correction, then HI/LO are written at the FIX edge and the FSM returns to IDLE. done=1 for the following cycle, busy=0 that same cycle.
- Latency: start at edge N gives HI/LO valid after edge N+XLEN+1, so 33 cycles for XLEN=32.
- Sign rules:
  - Signed product is negated if the operand signs differ.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Result placement: MUL puts the high half in HI and the low half in LO. DIV puts the remainder in HI and the quotient in LO.
- Boundary conditions:
  - Divide by zero (B=0): HI=A unmodified, LO=all ones. Full latency still applies.
  - DIV -2^31 / -1: LO=0x80000000, HI=0.
  - start while busy: ignored (the hazard unit guarantees it does not occur). The in-flight op is unaffected.
  - hi_we/lo_we while busy: ignored.
  - hi_we/lo_we while IDLE: write wdata at the edge.
  - hi_we/lo_we on the same edge as an accepted start: the write applies, then is overwritten at FIX.
- stall = mf_req & (busy | start). It is combinational and deasserts in the done cycle, so MFHI reads the new HI then.
- Operands are captured only at start. Later changes on rs_val/rt_val have no effect.

Decomposition:
- Shared package (pipeline defs) holds:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - the func-to-op map (0x18, 0x19, 0x1A, 0x1B);
  - FSM state encodings.
- One sub-module, muldiv_datapath: accumulator/remainder shift step and sign fix-up.
- The FSM, counter, HI/LO and stall logic stay in the top.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at cycle 0 -> done at cycle 34, HI=0xFFFFFFFE, LO=0x00000001, busy high cycles 1-33.
- MULT -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100 / 0 -> HI=100, LO=0xFFFFFFFF.
- mf_req=1 with start, and held through the op -> stall=1 every cycle until done; stall=0 in the done cycle. A second start pulsed mid-op -> no effect on the result.
- reset at cycle 10 of a DIVU -> hi=lo=0, busy=0, no done. A new MULTU 6 x 7 after reset -> LO=42, HI=0.
- hi_we with wdata=0x1234 while idle -> hi=0x1234 next cycle. lo_we while busy -> lo unchanged until FIX.
